// File: rtl/mouse_quad_pkg.sv
// Shared constants, types and the saturating adder for the mouse quadrature converter.
package mouse_quad_pkg;

    // Fixed point: two fractional bits, so one whole step is 4 counts.
    localparam int FRAC_W = 2;
    localparam int ONE    = 1 << FRAC_W;

    // Speed encoding, identical to the OSD option values.
    localparam logic [1:0] SPEED_100 = 2'b00;
    localparam logic [1:0] SPEED_200 = 2'b01;
    localparam logic [1:0] SPEED_25  = 2'b10;
    localparam logic [1:0] SPEED_50  = 2'b11;

    typedef enum logic {
        AXIS_IDLE,
        AXIS_RUN
    } axis_state_e;

    typedef struct packed {
        logic signed [31:0] val;
        logic               hit;
    } sat_res_t;

    // Add two values and clamp to the symmetric range of a w-bit signed
    // number; the most negative code is never produced.
    function automatic sat_res_t sat_add(input logic signed [31:0] a,
                                         input logic signed [31:0] b,
                                         input int unsigned        w);
        logic signed [31:0] lim;
        logic signed [31:0] sum;
        sat_res_t           r;
        lim   = (32'sd1 <<< (w - 1)) - 32'sd1;
        sum   = a + b;
        r.val = sum;
        r.hit = 1'b0;
        if (sum > lim) begin
            r.val = lim;
            r.hit = 1'b1;
        end else if (sum < -lim) begin
            r.val = -lim;
            r.hit = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/quad_axis.sv
// One axis: scaled saturating accumulator, rate-limited step engine,
// dir/clk outputs and Gray-code quadrature phase.
module quad_axis
    import mouse_quad_pkg::*;
#(
    parameter int ACC_W = 12,
    parameter int DIV_W = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   valid_i,
    input  logic signed [8:0]      delta_i,
    input  logic [1:0]             speed_i,
    input  logic                   flip_i,
    input  logic [DIV_W-1:0]       rate_div_i,
    output logic                   dir_o,
    output logic                   clk_o,
    output logic                   a_o,
    output logic                   b_o,
    output logic                   sat_o
);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [DIV_W-1:0]        cnt_q, cnt_d;
    logic [1:0]              phase_q, phase_d;
    logic                    dir_q, dir_d;
    logic                    tgl_q, tgl_d;
    logic                    sat_q, sat_d;

    axis_state_e             state;
    logic signed [31:0]      acc_ext;
    logic signed [31:0]      d_ext;
    logic signed [31:0]      scaled;
    logic signed [31:0]      step_amt;
    logic [DIV_W-1:0]        reload;
    sat_res_t                sum;
    logic                    sat_unused;

    assign acc_ext    = {{(32-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    assign d_ext      = {{23{delta_i[8]}}, delta_i};
    // A divider of 0 behaves like 1: step every clock.
    assign reload     = (rate_div_i == '0) ? '0 : rate_div_i - DIV_W'(1);
    // Clamped result always fits ACC_W, upper bits are pure sign copies.
    assign sat_unused = ^sum.val[31:ACC_W];

    // Classify the axis: RUN while at least one whole step is pending.
    always_comb begin
        state = AXIS_IDLE;
        if (acc_ext >= ONE || acc_ext <= -ONE) begin
            state = AXIS_RUN;
        end
    end

    // Step decision, counter, phase and the combined accumulate/step update.
    always_comb begin
        step_amt = '0;
        scaled   = '0;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        dir_d    = dir_q;
        tgl_d    = tgl_q;
        if (state == AXIS_RUN) begin
            if (cnt_q == '0) begin
                if (acc_ext > 0) begin
                    step_amt = ONE;
                    phase_d  = phase_q + 2'd1;
                    dir_d    = 1'b1;
                end else begin
                    step_amt = -ONE;
                    phase_d  = phase_q - 2'd1;
                    dir_d    = 1'b0;
                end
                tgl_d = ~tgl_q;
                cnt_d = reload;
            end else begin
                cnt_d = cnt_q - DIV_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
        if (valid_i) begin
            case (speed_i)
                SPEED_100: scaled = d_ext <<< 2;
                SPEED_200: scaled = d_ext <<< 3;
                SPEED_25:  scaled = d_ext;
                SPEED_50:  scaled = d_ext <<< 1;
                default:   scaled = '0;
            endcase
            if (flip_i) begin
                scaled = -scaled;
            end
        end
        // Step removal and new delta land in the same update: no lost counts.
        sum   = sat_add(acc_ext - step_amt, scaled, ACC_W);
        acc_d = sum.val[ACC_W-1:0];
        sat_d = sum.hit;
    end

    // State registers; reset clears the axis immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            phase_q <= 2'b00;
            dir_q   <= 1'b0;
            tgl_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            dir_q   <= dir_d;
            tgl_q   <= tgl_d;
            sat_q   <= sat_d;
        end
    end

    assign dir_o = dir_q;
    assign clk_o = tgl_q;
    assign a_o   = phase_q[1];
    assign b_o   = phase_q[1] ^ phase_q[0];
    assign sat_o = sat_q;

endmodule

// File: rtl/mouse_quadrature.sv
// Multi-axis motion-delta to trackball/spinner step converter.
// Pure wiring: one quad_axis per axis, all state lives in the axes.
module mouse_quadrature
    import mouse_quad_pkg::*;
#(
    parameter int NAXIS = 2,
    parameter int ACC_W = 12,
    parameter int DIV_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [NAXIS*9-1:0]   in_delta,
    input  logic [1:0]           speed,
    input  logic [NAXIS-1:0]     flip,
    input  logic [DIV_W-1:0]     rate_div,
    output logic [NAXIS-1:0]     out_dir,
    output logic [NAXIS-1:0]     out_clk,
    output logic [NAXIS-1:0]     out_a,
    output logic [NAXIS-1:0]     out_b,
    output logic [NAXIS-1:0]     sat
);

    for (genvar i = 0; i < NAXIS; i++) begin : g_axis
        quad_axis #(
            .ACC_W (ACC_W),
            .DIV_W (DIV_W)
        ) u_axis (
            .clk        (clk),
            .reset_n    (reset_n),
            .valid_i    (in_valid),
            .delta_i    (in_delta[9*i +: 9]),
            .speed_i    (speed),
            .flip_i     (flip[i]),
            .rate_div_i (rate_div),
            .dir_o      (out_dir[i]),
            .clk_o      (out_clk[i]),
            .a_o        (out_a[i]),
            .b_o        (out_b[i]),
            .sat_o      (sat[i])
        );
    end

endmodule

// File: tb/tb_mouse_quadrature.sv
// Directed, table-driven bench for mouse_quadrature (two-axis instance)
// plus a narrow ACC_W=8 single-axis instance for saturation.
module tb_mouse_quadrature;

    localparam int NAXIS = 2;
    localparam int ACC_W = 12;
    localparam int DIV_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_n;
    logic                 in_valid;
    logic [NAXIS*9-1:0]   in_delta;
    logic [1:0]           speed;
    logic [NAXIS-1:0]     flip;
    logic [DIV_W-1:0]     rate_div;
    logic [NAXIS-1:0]     out_dir, out_clk, out_a, out_b, sat;

    logic                 s_valid;
    logic [8:0]           s_delta;
    logic [1:0]           s_speed;
    logic [0:0]           s_flip;
    logic [7:0]           s_rate;
    logic [0:0]           s_dir, s_clk, s_a, s_b, s_sat;

    mouse_quadrature #(.NAXIS(NAXIS), .ACC_W(ACC_W), .DIV_W(DIV_W)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_delta(in_delta),
        .speed(speed), .flip(flip), .rate_div(rate_div),
        .out_dir(out_dir), .out_clk(out_clk), .out_a(out_a), .out_b(out_b), .sat(sat)
    );

    mouse_quadrature #(.NAXIS(1), .ACC_W(8), .DIV_W(8)) dut_sat (
        .clk(clk), .reset_n(reset_n), .in_valid(s_valid), .in_delta(s_delta),
        .speed(s_speed), .flip(s_flip), .rate_div(s_rate),
        .out_dir(s_dir), .out_clk(s_clk), .out_a(s_a), .out_b(s_b), .sat(s_sat)
    );

    typedef struct {
        int         ax;
        int         delta;
        logic [1:0] spd;
        logic       fl;
        int         rate;
        int         steps;
        logic       dir;
    } vec_t;

    vec_t       vt [7];
    int         total = 0;
    int         bad   = 0;
    logic [1:0] mph [NAXIS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [1:0] ab(input logic [1:0] p);
        return {p[1], p[1] ^ p[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int ax, input int delta);
        in_delta = '0;
        in_delta[9*ax +: 9] = 9'(delta);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_delta = '0;
    endtask

    // Watch ncyc cycles after a strobe; check step count, latency, spacing,
    // direction and Gray phase on every toggle, and silence on other axes.
    task automatic watch(input int ax, input int ncyc, input int rate, input int steps,
                         input logic dir, input int first_exp, input string tag);
        int n;
        int first;
        int last;
        int other;
        logic space_ok;
        logic [NAXIS-1:0] pclk;
        n = 0; first = -1; last = -1; other = 0; space_ok = 1'b1;
        pclk = out_clk;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            for (int a = 0; a < NAXIS; a++) begin
                if (out_clk[a] !== pclk[a]) begin
                    if (a == ax) begin
                        n++;
                        if (first < 0) first = c;
                        else if (c - last != rate) space_ok = 1'b0;
                        last = c;
                        mph[a] = dir ? mph[a] + 2'd1 : mph[a] - 2'd1;
                        check({tag, " ab"}, {30'd0, out_a[a], out_b[a]}, {30'd0, ab(mph[a])});
                        check({tag, " dir"}, {31'd0, out_dir[a]}, {31'd0, dir});
                    end else begin
                        other++;
                    end
                end
            end
            pclk = out_clk;
        end
        check({tag, " steps"}, n, steps);
        check({tag, " other_axis"}, other, 0);
        if (steps > 0) begin
            check({tag, " first"}, first, first_exp);
            check({tag, " spacing"}, {31'd0, space_ok}, 1);
        end
    endtask

    initial begin
        int n;
        int sn;
        logic [NAXIS-1:0] p;
        logic pc;

        vt[0] = '{0,  3, 2'b00, 1'b0, 4, 3, 1'b1};
        vt[1] = '{1, -2, 2'b00, 1'b1, 4, 2, 1'b1};
        vt[2] = '{1, -2, 2'b00, 1'b0, 4, 2, 1'b0};
        vt[3] = '{0,  2, 2'b11, 1'b0, 3, 1, 1'b1};
        vt[4] = '{0, -3, 2'b00, 1'b0, 0, 3, 1'b0};
        vt[5] = '{1,  1, 2'b01, 1'b0, 2, 2, 1'b1};
        vt[6] = '{0,  0, 2'b00, 1'b0, 4, 0, 1'b1};

        reset_n = 1'b0; in_valid = 1'b0; in_delta = '0; speed = 2'b00; flip = '0; rate_div = '0;
        s_valid = 1'b0; s_delta = '0; s_speed = 2'b00; s_flip = '0; s_rate = '0;
        for (int a = 0; a < NAXIS; a++) mph[a] = 2'b00;

        // Reset state
        repeat (3) tick();
        check("rst out_dir", {30'd0, out_dir}, 0);
        check("rst out_clk", {30'd0, out_clk}, 0);
        check("rst out_a", {30'd0, out_a}, 0);
        check("rst out_b", {30'd0, out_b}, 0);
        check("rst sat", {30'd0, sat}, 0);
        check("rst sat_dut clk", {31'd0, s_clk}, 0);
        reset_n = 1'b1;
        tick();

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            speed = vt[i].spd;
            flip = '0;
            flip[vt[i].ax] = vt[i].fl;
            rate_div = DIV_W'(vt[i].rate);
            strobe(vt[i].ax, vt[i].delta);
            watch(vt[i].ax, vt[i].steps * ((vt[i].rate < 1) ? 1 : vt[i].rate) + 4,
                  (vt[i].rate < 1) ? 1 : vt[i].rate, vt[i].steps, vt[i].dir, 1,
                  $sformatf("vec%0d", i));
        end
        flip = '0;

        // Fractional: 25% speed, remainders kept
        speed = 2'b10; rate_div = 8'd2;
        for (int i = 0; i < 3; i++) begin
            strobe(0, 1);
            watch(0, 3, 2, 0, 1'b1, 1, $sformatf("frac_pre%0d", i));
        end
        strobe(0, 1);
        watch(0, 6, 2, 1, 1'b1, 1, "frac_4th");
        strobe(0, -1);
        watch(0, 6, 2, 0, 1'b0, 1, "frac_neg1");
        strobe(0, -3);
        watch(0, 6, 2, 1, 1'b0, 1, "frac_neg4");

        // Simultaneous strobe and step: acc 8 -> 8-4+4 = 8
        speed = 2'b00; rate_div = 8'd4;
        pc = out_clk[0];
        in_delta = '0; in_delta[8:0] = 9'd2; in_valid = 1'b1;
        tick();
        check("simul no_early", {31'd0, out_clk[0] ^ pc}, 0);
        in_delta[8:0] = 9'd1;
        tick();
        in_valid = 1'b0; in_delta = '0;
        check("simul step_edge", {31'd0, out_clk[0] ^ pc}, 1);
        mph[0] = mph[0] + 2'd1;
        check("simul ab", {30'd0, out_a[0], out_b[0]}, {30'd0, ab(mph[0])});
        watch(0, 12, 4, 2, 1'b1, 4, "simul_rest");

        // Both axes step on the same edge, rate_div=0
        rate_div = 8'd0;
        in_delta = '0; in_delta[8:0] = 9'd1; in_delta[17:9] = 9'h1FF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_delta = '0;
        p = out_clk;
        tick();
        check("both toggled", {30'd0, out_clk ^ p}, 2'b11);
        check("both dir", {30'd0, out_dir}, 2'b01);
        mph[0] = mph[0] + 2'd1;
        mph[1] = mph[1] - 2'd1;
        check("both ab0", {30'd0, out_a[0], out_b[0]}, {30'd0, ab(mph[0])});
        check("both ab1", {30'd0, out_a[1], out_b[1]}, {30'd0, ab(mph[1])});
        watch(0, 4, 1, 0, 1'b1, 1, "both_quiet");

        // Asynchronous reset mid-stream
        rate_div = 8'd2; speed = 2'b00;
        pc = out_clk[0];
        strobe(0, 20);
        repeat (5) tick();
        check("midrst pre_clk", {31'd0, out_clk[0]}, {31'd0, ~pc});
        check("midrst pre_dir", {31'd0, out_dir[0]}, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst out_dir", {30'd0, out_dir}, 0);
        check("midrst out_clk", {30'd0, out_clk}, 0);
        check("midrst out_ab", {28'd0, out_a, out_b}, 0);
        check("midrst sat", {30'd0, sat}, 0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int a = 0; a < NAXIS; a++) mph[a] = 2'b00;
        watch(0, 30, 2, 0, 1'b1, 1, "midrst_after");

        // Saturation on the ACC_W=8 instance: 2040 clamps to 127
        s_speed = 2'b01; s_rate = 8'd1; s_delta = 9'd255; s_valid = 1'b1;
        tick();
        s_valid = 1'b0; s_delta = '0;
        check("sat pulse", {31'd0, s_sat}, 1);
        n = 0; sn = 0; pc = s_clk[0];
        for (int c = 0; c < 40; c++) begin
            tick();
            if (s_clk[0] !== pc) n++;
            if (s_sat[0] === 1'b1) sn++;
            pc = s_clk[0];
        end
        check("sat steps", n, 31);
        check("sat extra_pulses", sn, 0);
        check("sat dir", {31'd0, s_dir}, 1);
        s_speed = 2'b10; s_delta = 9'd1; s_valid = 1'b1;
        tick();
        s_valid = 1'b0; s_delta = '0;
        n = 0; pc = s_clk[0];
        for (int c = 0; c < 8; c++) begin
            tick();
            if (s_clk[0] !== pc) n++;
            pc = s_clk[0];
        end
        check("sat remainder3", n, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
